// File: rtl/spi_daisy_chain.sv
// SPI daisy-chain demonstrator: an internal master sends one byte into a chain
// of slaves; each slave re-sends its byte downstream, and the last one drives dout.
module spi_daisy_chain #(
  parameter int unsigned NUM_SLAVES = 2,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       newd,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE} tx_state_e;

  // Stage k owns the transmitter of link k and the receiver (slave k) at its far end.
  // Link 0 is driven by the master; link k>0 is driven by slave k-1 forwarding its byte.
  for (genvar k = 0; k < NUM_SLAVES; k++) begin : stage
    logic             start;
    logic [7:0]       tx_byte;
    tx_state_e        state, state_d;
    logic             cs, cs_d, sclk, sclk_d, mosi, mosi_d;
    logic [7:0]       sh, sh_d;
    logic [DIV_W-1:0] div_cnt, div_d;
    logic [3:0]       edg, edg_d;
    logic             l_sclk, l_cs, l_mosi;
    logic             sclk_q, cs_q;
    logic [7:0]       rx_sh;
    logic [3:0]       rx_cnt;
    logic             rx_valid_c;

    // Transmit source and the wires the receiver listens on.
    if (k == 0) begin : g_src
      assign start   = newd;
      assign tx_byte = din;
      assign l_sclk  = master.sclk;
      assign l_cs    = master.cs;
      assign l_mosi  = master.mosi;
    end else begin : g_src
      assign start   = stage[k-1].g_fwd.pend;
      assign tx_byte = stage[k-1].g_fwd.pend_byte;
      assign l_sclk  = sclk;
      assign l_cs    = cs;
      assign l_mosi  = mosi;
    end

    // Transmitter state and line registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state   <= ST_IDLE;
        cs      <= 1'b1;
        sclk    <= 1'b0;
        mosi    <= 1'b0;
        sh      <= '0;
        div_cnt <= '0;
        edg     <= '0;
      end else begin
        state   <= state_d;
        cs      <= cs_d;
        sclk    <= sclk_d;
        mosi    <= mosi_d;
        sh      <= sh_d;
        div_cnt <= div_d;
        edg     <= edg_d;
      end
    end

    // Transmitter next state: 16 sclk edges per frame, mosi shifts on falling edges.
    always_comb begin
      state_d = state;
      cs_d    = cs;
      sclk_d  = sclk;
      mosi_d  = mosi;
      sh_d    = sh;
      div_d   = div_cnt;
      edg_d   = edg;
      unique case (state)
        ST_IDLE: begin
          cs_d   = 1'b1;
          sclk_d = 1'b0;
          if (start) begin
            sh_d    = tx_byte;
            mosi_d  = tx_byte[7];
            cs_d    = 1'b0;
            div_d   = '0;
            edg_d   = '0;
            state_d = ST_SEND;
          end
        end
        ST_SEND: begin
          if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
            div_d  = '0;
            sclk_d = ~sclk;
            edg_d  = edg + 4'd1;
            if (sclk) begin
              sh_d   = {sh[6:0], 1'b0};
              mosi_d = sh[6];
              if (edg == 4'd15) state_d = ST_DONE;
            end
          end else begin
            div_d = div_cnt + DIV_W'(1);
          end
        end
        ST_DONE: begin
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Receiver: shift on sclk rise while selected; byte valid on cs rise after >=8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sclk_q <= 1'b0;
        cs_q   <= 1'b1;
        rx_sh  <= '0;
        rx_cnt <= '0;
      end else begin
        sclk_q <= l_sclk;
        cs_q   <= l_cs;
        if (!l_cs && l_sclk && !sclk_q) begin
          rx_sh <= {rx_sh[6:0], l_mosi};
          if (rx_cnt != 4'd8) rx_cnt <= rx_cnt + 4'd1;
        end else if (l_cs && !cs_q) begin
          rx_cnt <= '0;
        end
      end
    end

    assign rx_valid_c = l_cs && !cs_q && (rx_cnt == 4'd8);

    // One-deep forward queue; a newer byte overwrites one still waiting.
    if (k < NUM_SLAVES - 1) begin : g_fwd
      logic       pend;
      logic [7:0] pend_byte;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pend      <= 1'b0;
          pend_byte <= '0;
        end else if (rx_valid_c) begin
          pend      <= 1'b1;
          pend_byte <= rx_sh;
        end else if (stage[k+1].state == ST_IDLE) begin
          pend      <= 1'b0;
        end
      end
    end
  end

  // Named view of the master's link for observation.
  if (1'b1) begin : master
    logic sclk, cs, mosi;
    assign sclk = stage[0].sclk;
    assign cs   = stage[0].cs;
    assign mosi = stage[0].mosi;
  end

  // Last slave's byte lands on dout the clock after its frame closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (stage[NUM_SLAVES-1].rx_valid_c) begin
      dout <= stage[NUM_SLAVES-1].rx_sh;
    end
  end

endmodule

// File: tb/tb_spi_daisy_chain.sv
// Scoreboard bench for spi_daisy_chain: every byte sent is expected once on the
// master link and once on dout, in order.
module tb_spi_daisy_chain;

  localparam int unsigned NS  = 2;
  localparam int unsigned CD  = 4;
  localparam int unsigned LAT = NS * (16 * CD + 4);

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       newd  = 1'b0;
  logic [7:0] din   = 8'h00;
  logic [7:0] dout;

  spi_daisy_chain #(.NUM_SLAVES(NS), .CLK_DIV(CD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .newd (newd),
    .din  (din),
    .dout (dout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_m[$];
  logic [7:0] exp_d[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Master link monitor: collects mosi at each sclk rise inside a cs-low window.
  logic       m_in = 1'b0;
  logic       m_pcs = 1'b1;
  logic       m_psclk = 1'b0;
  int         m_rises = 0;
  logic [7:0] m_bits = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_in    = 1'b0;
      m_rises = 0;
    end else begin
      if (m_pcs && !dut.master.cs) begin
        m_in    = 1'b1;
        m_rises = 0;
        m_bits  = 8'h00;
      end
      if (m_in && dut.master.sclk && !m_psclk) begin
        m_bits = {m_bits[6:0], dut.master.mosi};
        m_rises++;
      end
      if (m_in && dut.master.cs && !m_pcs) begin
        m_in = 1'b0;
        if (exp_m.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_master_frame: got 0x%0h, expected none", m_bits);
        end else begin
          logic [7:0] e;
          e = exp_m.pop_front();
          check("master_sclk_rises", 32'(m_rises), 32'd8);
          check("master_mosi_byte", 32'(m_bits), 32'(e));
        end
      end
    end
    m_pcs   = dut.master.cs;
    m_psclk = dut.master.sclk;
  end

  // dout monitor: the last slave's valid strobe announces a dout update next clock.
  logic d_upd = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      d_upd = 1'b0;
    end else begin
      if (d_upd) begin
        if (exp_d.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_dout: got 0x%0h, expected none", dout);
        end else begin
          logic [7:0] e;
          e = exp_d.pop_front();
          check("dout_byte", 32'(dout), 32'(e));
        end
      end
      d_upd = dut.stage[NS-1].rx_valid_c;
    end
  end

  task automatic send(input logic [7:0] b);
    din  = b;
    newd = 1'b1;
    exp_m.push_back(b);
    exp_d.push_back(b);
    tick();
    newd = 1'b0;
  endtask

  task automatic drain(input int limit, output int used);
    used = 0;
    while ((exp_m.size() != 0 || exp_d.size() != 0) && used < limit) begin
      tick();
      used++;
    end
    if (exp_m.size() != 0 || exp_d.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_m.size() + exp_d.size());
      exp_m.delete();
      exp_d.delete();
    end
    repeat (3) tick();
  endtask

  initial begin
    int n;
    int used;
    int rises;
    logic prev;
    logic seen_low;
    logic seen_rise;
    logic [7:0] b;

    // Reset state
    repeat (3) tick();
    check("rst_dout", 32'(dout), 32'h00);
    check("rst_master_cs", 32'(dut.master.cs), 32'd1);
    check("rst_master_sclk", 32'(dut.master.sclk), 32'd0);
    check("rst_last_cs", 32'(dut.stage[NS-1].cs), 32'd1);
    rst_n = 1'b1;
    repeat (5) tick();

    // Single byte, newd held until first master sclk rise; latency bound
    din  = 8'hA5;
    newd = 1'b1;
    exp_m.push_back(8'hA5);
    exp_d.push_back(8'hA5);
    n = 0;
    while (dut.master.sclk !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("t2_sclk_start", 32'(dut.master.sclk), 32'd1);
    newd = 1'b0;
    drain(2 * LAT, used);
    check("t2_latency_ok", 32'((n + used) <= int'(LAT) + 3), 32'd1);
    check("t2_dout", 32'(dout), 32'hA5);

    // Busy ignore: newd pulse mid-frame must not start a frame
    send(8'h81);
    repeat (20) tick();
    din  = 8'h3C;
    newd = 1'b1;
    tick();
    newd = 1'b0;
    drain(2 * LAT, used);
    repeat (LAT) tick();
    check("t3_dout", 32'(dout), 32'h81);

    // Back-to-back with newd held high
    din  = 8'h0F;
    newd = 1'b1;
    exp_m.push_back(8'h0F);
    exp_d.push_back(8'h0F);
    seen_low  = 1'b0;
    seen_rise = 1'b0;
    n = 0;
    while (!seen_rise && n < int'(LAT)) begin
      tick();
      n++;
      if (dut.master.cs == 1'b0) seen_low = 1'b1;
      else if (seen_low) seen_rise = 1'b1;
    end
    check("t4_first_cs_rise", 32'(seen_rise), 32'd1);
    din = 8'hF0;
    exp_m.push_back(8'hF0);
    exp_d.push_back(8'hF0);
    n = 0;
    while (dut.master.cs !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    check("t4_second_cs_fall", 32'(dut.master.cs), 32'd0);
    newd = 1'b0;
    drain(3 * LAT, used);
    check("t4_dout", 32'(dout), 32'hF0);

    // Reset mid-frame after 4 master sclk rises
    din  = 8'hC3;
    newd = 1'b1;
    tick();
    newd = 1'b0;
    rises = 0;
    prev  = 1'b0;
    n = 0;
    while (rises < 4 && n < 200) begin
      tick();
      n++;
      if (dut.master.sclk && !prev) rises++;
      prev = dut.master.sclk;
    end
    check("t5_four_rises", 32'(rises), 32'd4);
    rst_n = 1'b0;
    #1;
    check("t5_rst_master_cs", 32'(dut.master.cs), 32'd1);
    check("t5_rst_last_cs", 32'(dut.stage[NS-1].cs), 32'd1);
    check("t5_rst_sclk", 32'(dut.master.sclk), 32'd0);
    check("t5_rst_dout", 32'(dout), 32'h00);
    exp_m.delete();
    exp_d.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2 * LAT) tick();
    check("t5_no_partial", 32'(dout), 32'h00);
    send(8'h5A);
    drain(2 * LAT, used);
    check("t5_dout", 32'(dout), 32'h5A);

    // Random bytes, one at a time
    for (int i = 0; i < 50; i++) begin
      b = 8'($urandom_range(0, 255));
      send(b);
      drain(2 * LAT, used);
    end

    repeat (LAT) tick();
    check("end_master_queue", 32'(exp_m.size()), 32'd0);
    check("end_dout_queue", 32'(exp_d.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
